// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for alu_multicycle.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic zero;
      logic gez;
      logic carry;
      logic ovf;
      logic illegal;
   } flags_t;

   // Flags of a zero result with nothing else set.
   localparam flags_t FLAGS_RST = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   function automatic flags_t plain_flags(input logic is_zero, input logic msb);
      flags_t f;
      f = '{is_zero, ~msb, 1'b0, 1'b0, 1'b0};
      return f;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps after start.
module alu_mul_iter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   // done marks the cycle performing the final step; product is that step's sum.
   assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign product = acc_d;

   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
      end else if (busy_q) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (done) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU with registered result/flags; MUL uses alu_mul_iter only when
// ALU_MULTICYCLE_MUL_EN is defined, otherwise opcode 1000 is treated as illegal.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             gez,
   output logic             carry,
   output logic             ovf,
   output logic             illegal
);

   state_e                  state_q, state_d;
   logic [WIDTH-1:0]        result_q, result_d;
   flags_t                  flags_q, flags_d;
   logic [WIDTH-1:0]        alu_res;
   flags_t                  alu_flags;
   logic [WIDTH:0]          add_w, sub_w;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic                    accept;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = flags_q.zero;
   assign gez       = flags_q.gez;
   assign carry     = flags_q.carry;
   assign ovf       = flags_q.ovf;
   assign illegal   = flags_q.illegal;
   assign a_s       = a;
   assign b_s       = b;

`ifdef ALU_MULTICYCLE_MUL_EN
   logic             mul_start, mul_done;
   logic [WIDTH-1:0] mul_product;

   assign mul_start = accept && (alu_op == OP_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   // Single-cycle datapath, evaluated on the operands offered this cycle.
   always_comb begin
      add_w     = {1'b0, a} + {1'b0, b};
      sub_w     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      alu_res   = '0;
      alu_flags = FLAGS_RST;
      case (alu_op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_NOR: alu_res = ~(a | b);
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_ADD: alu_res = add_w[WIDTH-1:0];
         OP_SUB: alu_res = sub_w[WIDTH-1:0];
         default: alu_res = '0;
      endcase
      alu_flags = plain_flags(alu_res == '0, alu_res[WIDTH-1]);
      case (alu_op)
         OP_AND, OP_OR, OP_NOR, OP_SLT: ;
         OP_ADD: begin
            alu_flags.carry = add_w[WIDTH];
            alu_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_flags.carry = sub_w[WIDTH];
            alu_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         default: alu_flags.illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         BUSY: begin
`ifdef ALU_MULTICYCLE_MUL_EN
            if (mul_done) begin
               state_d  = DONE;
               result_d = mul_product;
               flags_d  = plain_flags(mul_product == '0, mul_product[WIDTH-1]);
            end
`else
            state_d = IDLE;
`endif
         end
         DONE: if (out_ready) state_d = IDLE;
         default: ;
      endcase
      // An acceptance in DONE overrides the return to IDLE, so there is no bubble.
      if (accept) begin
         state_d  = DONE;
         result_d = alu_res;
         flags_d  = alu_flags;
`ifdef ALU_MULTICYCLE_MUL_EN
         if (alu_op == OP_MUL) begin
            state_d  = BUSY;
            result_d = result_q;
            flags_d  = flags_q;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= FLAGS_RST;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed corner cases, then randomized traffic.
module tb_alu_multicycle;

   localparam int W = 64;
`ifdef ALU_MULTICYCLE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam int MUL_LAT = MUL_EN ? W + 1 : 1;

   typedef struct packed {
      logic [W-1:0] res;
      logic         zero;
      logic         gez;
      logic         carry;
      logic         ovf;
      logic         illegal;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   alu_op = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         zero, gez, carry, ovf, illegal;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   bit   ordy_rand = 1'b0;
   bit   ordy_fixed = 1'b1;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .alu_op    (alu_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .gez       (gez),
      .carry     (carry),
      .ovf       (ovf),
      .illegal   (illegal)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model from the arithmetic definitions of each opcode.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t                e;
      logic [W:0]          wsum;
      logic [2*W-1:0]      prod;
      logic signed [W+1:0] sx, sy, ss;
      e  = '0;
      sx = $signed({{2{x[W-1]}}, x});
      sy = $signed({{2{y[W-1]}}, y});
      case (op)
         4'b0000: e.res = x & y;
         4'b0001: e.res = x | y;
         4'b1100: e.res = ~(x | y);
         4'b0010: begin
            wsum    = {1'b0, x} + {1'b0, y};
            e.res   = wsum[W-1:0];
            e.carry = wsum[W];
            ss      = sx + sy;
            e.ovf   = (ss != $signed({{2{e.res[W-1]}}, e.res}));
         end
         4'b0110: begin
            e.res   = x - y;
            e.carry = (x >= y);
            ss      = sx - sy;
            e.ovf   = (ss != $signed({{2{e.res[W-1]}}, e.res}));
         end
         4'b0111: e.res[0] = (sx < sy);
         4'b1000: begin
            if (MUL_EN) begin
               prod  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
               e.res = prod[W-1:0];
            end else begin
               e.illegal = 1'b1;
            end
         end
         default: e.illegal = 1'b1;
      endcase
      e.zero = (e.res == '0);
      e.gez  = ~e.res[W-1];
      return e;
   endfunction

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = {1'b0, {(W-1){1'b1}}};
         3: v = {1'b1, {(W-1){1'b0}}};
         4: v = W'($urandom_range(0, 15));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   function automatic logic [3:0] rand_op();
      logic [3:0] o;
      case ($urandom_range(0, 8))
         0: o = 4'b0000;
         1: o = 4'b0001;
         2: o = 4'b0010;
         3: o = 4'b0110;
         4: o = 4'b1100;
         5: o = 4'b0111;
         6: o = 4'b1000;
         7: o = 4'($urandom);
         default: o = 4'b0010;
      endcase
      return o;
   endfunction

   initial forever begin
      @(negedge clk);
      out_ready = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_fixed;
   end

   // Monitor: every presented result must match the oldest outstanding expectation.
   initial forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
         check("sb_nonempty", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            check("sb_result", {result, zero, gez, carry, ovf, illegal}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int waits);
      waits = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      alu_op   = op;
      #2;
      while (!in_ready && waits < 300) begin
         @(negedge clk);
         #2;
         waits++;
      end
      if (!in_ready) begin
         check("issue_timeout", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(op, av, bv));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cycles, output int nrdy);
      cycles = 0;
      nrdy   = 0;
      do begin
         @(negedge clk);
         #2;
         cycles++;
         if (!in_ready) nrdy++;
      end while (!out_valid && cycles < 300);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int           w, lat, nr, tot, cnt;
      logic [W-1:0] mres;

      repeat (3) @(negedge clk);
      #2;
      check("rst_flags", {out_valid, in_ready, zero, gez, carry, ovf, illegal}, 7'b0111000);
      check("rst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("rst_release_ready", in_ready, 1);

      issue(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, w);
      wait_valid(lat, nr);
      check("add_lat", lat, 1);
      check("add_ovf", {result, zero, gez, carry, ovf, illegal},
            {64'h8000_0000_0000_0000, 5'b00010});

      issue(4'b0110, 64'd5, 64'd5, w);
      wait_valid(lat, nr);
      check("sub_eq", {result, zero, gez, carry, ovf, illegal}, {64'd0, 5'b11100});

      issue(4'b0110, 64'd3, 64'd5, w);
      wait_valid(lat, nr);
      check("sub_neg", {result, zero, gez, carry, ovf, illegal},
            {64'hFFFF_FFFF_FFFF_FFFE, 5'b00000});

      issue(4'b1111, rand_operand(), rand_operand(), w);
      wait_valid(lat, nr);
      check("illegal_lat", lat, 1);
      check("illegal_op", {result, zero, gez, carry, ovf, illegal}, {64'd0, 5'b11001});

      ordy_fixed = 1'b0;
      issue(4'b1000, 64'd3, 64'd7, w);
      wait_valid(lat, nr);
      check("mul_lat", lat, MUL_LAT);
      check("mul_not_ready", nr, MUL_LAT);
      mres = MUL_EN ? 64'd21 : 64'd0;
      check("mul_value", {result, zero, gez, carry, ovf, illegal},
            {mres, 1'b0 ^ !MUL_EN, 1'b1, 2'b00, !MUL_EN});
      repeat (10) begin
         @(negedge clk);
         #2;
         check("mul_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, mres});
      end
      ordy_fixed = 1'b1;
      drain();

      tot = 0;
      for (int i = 0; i < 8; i++) begin
         issue(4'b0010, rand_operand(), rand_operand(), w);
         tot += w;
         check("b2b_valid", out_valid, 1);
      end
      check("b2b_waits", tot, 0);
      drain();

      ordy_fixed = 1'b0;
      issue(4'b1000, rand_operand(), rand_operand(), w);
      repeat (20) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async", {out_valid, in_ready, result, zero, gez, carry, ovf, illegal},
            {1'b0, 1'b1, 64'd0, 5'b11000});
      exp_q.delete();
      @(negedge clk);
      #1;
      rst_n      = 1'b1;
      ordy_fixed = 1'b1;
      #1;
      check("rst_release_ready2", in_ready, 1);
      cnt = 0;
      repeat (80) begin
         @(negedge clk);
         #2;
         if (out_valid) cnt++;
      end
      check("rst_discard", cnt, 0);

      ordy_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            a = rand_operand();
         end
         issue(rand_op(), rand_operand(), rand_operand(), w);
      end
      ordy_rand  = 1'b0;
      ordy_fixed = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
